// File: rtl/selector_tablero.sv
// Cursor and mark placement over an N x N board.
// Turn alternation, occupancy checks and board-full flag.
module selector_tablero #(
  parameter int N  = 3,
  parameter int CW = $clog2(N*N+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boton_arriba,
  input  logic              boton_abajo,
  input  logic              boton_izq,
  input  logic              boton_der,
  input  logic              boton_elige,
  input  logic              habilita,
  input  logic              nuevo_juego,
  output logic [CW-1:0]     cuadro,
  output logic [2*N*N-1:0]  tablero,
  output logic              turno_p1,
  output logic              turno_p2,
  output logic              p1_mm,
  output logic              p2_mm,
  output logic              jugada_valida,
  output logic              jugada_invalida,
  output logic              lleno
);

  localparam int NN = N * N;
  localparam int RW = $clog2(N);
  localparam int MID = (N - 1) / 2;

  localparam logic [RW-1:0] CENTRE = RW'(MID);
  localparam logic [RW-1:0] TOP    = RW'(N - 1);
  localparam logic [CW-1:0] HOME   = CW'(MID * N + MID + 1);
  localparam logic [CW-1:0] FULL   = CW'(NN);

  // button bit order: abajo, arriba, izq, der, elige
  localparam int B_AB = 0;
  localparam int B_AR = 1;
  localparam int B_IZ = 2;
  localparam int B_DE = 3;
  localparam int B_EL = 4;

  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     col_q, col_d;
  logic [CW-1:0]     cuadro_q;
  logic [2*NN-1:0]   tab_q, tab_d;
  logic              turno_q, turno_d;
  logic              p1_q, p1_d;
  logic              p2_q, p2_d;
  logic              val_q, val_d;
  logic              inv_q, inv_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lleno_q;
  logic [4:0]        prev_q;
  logic [4:0]        btn;
  logic [4:0]        press;
  int                idx;
  logic              occ;

  assign btn = {boton_elige, boton_der, boton_izq,
                boton_arriba, boton_abajo};
  assign press = btn & ~prev_q;

  // Next state: only the highest-priority press acts this cycle
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    tab_d   = tab_q;
    turno_d = turno_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    val_d   = 1'b0;
    inv_d   = 1'b0;
    cnt_d   = cnt_q;
    idx     = int'(row_q) * N + int'(col_q);
    occ     = (tab_q[2*idx +: 2] != 2'b00);
    if (nuevo_juego) begin
      tab_d   = '0;
      turno_d = 1'b1;
      p1_d    = 1'b0;
      p2_d    = 1'b0;
      cnt_d   = '0;
    end else if (press[B_AB]) begin
      if (row_q != '0) row_d = row_q - 1'b1;
    end else if (press[B_AR]) begin
      if (row_q != TOP) row_d = row_q + 1'b1;
    end else if (press[B_IZ]) begin
      if (col_q != '0) col_d = col_q - 1'b1;
    end else if (press[B_DE]) begin
      if (col_q != TOP) col_d = col_q + 1'b1;
    end else if (press[B_EL] && habilita) begin
      if (occ) begin
        inv_d = 1'b1;
      end else begin
        tab_d[2*idx +: 2] = turno_q ? 2'b11 : 2'b01;
        p1_d    = turno_q;
        p2_d    = ~turno_q;
        turno_d = ~turno_q;
        val_d   = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q    <= CENTRE;
      col_q    <= CENTRE;
      cuadro_q <= HOME;
      tab_q    <= '0;
      turno_q  <= 1'b1;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      val_q    <= 1'b0;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
      lleno_q  <= 1'b0;
      prev_q   <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      cuadro_q <= CW'(int'(row_d) * N + int'(col_d) + 1);
      tab_q    <= tab_d;
      turno_q  <= turno_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      val_q    <= val_d;
      inv_q    <= inv_d;
      cnt_q    <= cnt_d;
      lleno_q  <= (cnt_d == FULL);
      prev_q   <= btn;
    end
  end

  assign cuadro          = cuadro_q;
  assign tablero         = tab_q;
  assign turno_p1        = turno_q;
  assign turno_p2        = ~turno_q;
  assign p1_mm           = p1_q;
  assign p2_mm           = p2_q;
  assign jugada_valida   = val_q;
  assign jugada_invalida = inv_q;
  assign lleno           = lleno_q;

endmodule

// File: tb/tb_selector_tablero.sv
// Directed bench for selector_tablero.
// N=3 instance for function, N=4 instance for the parameter sweep.
module tb_selector_tablero;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // N = 3 instance
  logic        rst3, hab3, nj3;
  logic [4:0]  b3;
  logic [3:0]  cuadro3;
  logic [17:0] tab3;
  logic        t1_3, t2_3, p1_3, p2_3, val3, inv3, lleno3;

  selector_tablero #(.N(3)) u3 (
    .clk(clk), .reset(rst3),
    .boton_arriba(b3[1]), .boton_abajo(b3[0]),
    .boton_izq(b3[2]), .boton_der(b3[3]),
    .boton_elige(b3[4]), .habilita(hab3),
    .nuevo_juego(nj3), .cuadro(cuadro3),
    .tablero(tab3), .turno_p1(t1_3), .turno_p2(t2_3),
    .p1_mm(p1_3), .p2_mm(p2_3),
    .jugada_valida(val3), .jugada_invalida(inv3),
    .lleno(lleno3)
  );

  // N = 4 instance
  logic        rst4, hab4, nj4;
  logic [4:0]  b4;
  logic [4:0]  cuadro4;
  logic [31:0] tab4;
  logic        t1_4, t2_4, p1_4, p2_4, val4, inv4, lleno4;

  selector_tablero #(.N(4)) u4 (
    .clk(clk), .reset(rst4),
    .boton_arriba(b4[1]), .boton_abajo(b4[0]),
    .boton_izq(b4[2]), .boton_der(b4[3]),
    .boton_elige(b4[4]), .habilita(hab4),
    .nuevo_juego(nj4), .cuadro(cuadro4),
    .tablero(tab4), .turno_p1(t1_4), .turno_p2(t2_4),
    .p1_mm(p1_4), .p2_mm(p2_4),
    .jugada_valida(val4), .jugada_invalida(inv4),
    .lleno(lleno4)
  );

  // button index: 0 abajo, 1 arriba, 2 izq, 3 der, 4 elige
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press3(input int b);
    tick();
    b3[b] = 1'b1;
    tick();
    b3[b] = 1'b0;
  endtask

  task automatic press4(input int b);
    tick();
    b4[b] = 1'b1;
    tick();
    b4[b] = 1'b0;
  endtask

  task automatic test_reset();
    rst3 = 1'b1; rst4 = 1'b1;
    hab3 = 1'b1; hab4 = 1'b1;
    nj3 = 1'b0; nj4 = 1'b0;
    b3 = '0; b4 = '0;
    tick(); tick();
    rst3 = 1'b0; rst4 = 1'b0;
    n_chk++;
    if (cuadro3 !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_cuadro got %0d want 5", cuadro3);
    end
    n_chk++;
    if (tab3 !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_tablero got %h want 0", tab3);
    end
    n_chk++;
    if ({t1_3, t2_3, lleno3} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_turn_lleno got %b want 100",
               {t1_3, t2_3, lleno3});
    end
    n_chk++;
    if ({p1_3, p2_3, val3, inv3} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {p1_3, p2_3, val3, inv3});
    end
  endtask

  task automatic test_hold();
    tick();
    b3[1] = 1'b1;
    tick();
    n_chk++;
    if (cuadro3 !== 4'd8) begin
      n_fail++;
      $display("FAIL hold_first got %0d want 8", cuadro3);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_chk++;
      if (cuadro3 !== 4'd8) begin
        n_fail++;
        $display("FAIL hold_repeat cyc %0d got %0d want 8",
                 i, cuadro3);
      end
    end
    b3[1] = 1'b0;
  endtask

  task automatic test_clamp();
    int seq [8] = '{0, 2, 2, 0, 0, 3, 3, 3};
    int exp [8] = '{5, 4, 4, 1, 1, 2, 3, 3};
    for (int i = 0; i < 8; i++) begin
      press3(seq[i]);
      n_chk++;
      if (cuadro3 !== 4'(exp[i])) begin
        n_fail++;
        $display("FAIL clamp step %0d got %0d want %0d",
                 i, cuadro3, exp[i]);
      end
    end
    press3(1);
    press3(2);
    n_chk++;
    if (cuadro3 !== 4'd5) begin
      n_fail++;
      $display("FAIL clamp_return got %0d want 5", cuadro3);
    end
  endtask

  task automatic test_elige();
    press3(4);
    n_chk++;
    if (tab3 !== 18'h300) begin
      n_fail++;
      $display("FAIL valid_board got %h want 00300", tab3);
    end
    n_chk++;
    if ({val3, inv3, t1_3, t2_3, p1_3, p2_3} !== 6'b100110) begin
      n_fail++;
      $display("FAIL valid_flags got %b want 100110",
               {val3, inv3, t1_3, t2_3, p1_3, p2_3});
    end
    tick();
    n_chk++;
    if (val3 !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse_len got %b want 0", val3);
    end
    press3(4);
    n_chk++;
    if ({val3, inv3, t1_3} !== 3'b010) begin
      n_fail++;
      $display("FAIL invalid_flags got %b want 010",
               {val3, inv3, t1_3});
    end
    n_chk++;
    if (tab3 !== 18'h300) begin
      n_fail++;
      $display("FAIL invalid_board got %h want 00300", tab3);
    end
    tick();
    n_chk++;
    if (inv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_pulse_len got %b want 0", inv3);
    end
  endtask

  task automatic test_simul();
    tick();
    b3 = 5'b11001;
    tick();
    b3 = '0;
    n_chk++;
    if (cuadro3 !== 4'd2) begin
      n_fail++;
      $display("FAIL simul_cuadro got %0d want 2", cuadro3);
    end
    n_chk++;
    if ({tab3, val3, inv3} !== {18'h300, 2'b00}) begin
      n_fail++;
      $display("FAIL simul_nomark got %h/%b%b want 00300/00",
               tab3, val3, inv3);
    end
  endtask

  task automatic test_habilita();
    hab3 = 1'b0;
    press3(4);
    n_chk++;
    if ({tab3, val3, inv3, t1_3} !== {18'h300, 3'b000}) begin
      n_fail++;
      $display("FAIL habilita_off got %h/%b%b%b want 00300/000",
               tab3, val3, inv3, t1_3);
    end
    hab3 = 1'b1;
  endtask

  task automatic test_fill();
    int mv [9] = '{2, 3, 3, 1, 2, 2, 1, 3, 3};
    int cl [9] = '{1, 2, 3, 6, 5, 4, 7, 8, 9};
    logic [17:0] exp3;
    exp3 = '0;
    tick();
    nj3 = 1'b1;
    tick();
    nj3 = 1'b0;
    n_chk++;
    if ({tab3, t1_3, cuadro3} !== {18'h0, 1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL clear_before_fill got %h/%b/%0d want 0/1/2",
               tab3, t1_3, cuadro3);
    end
    for (int i = 0; i < 9; i++) begin
      press3(mv[i]);
      n_chk++;
      if (cuadro3 !== 4'(cl[i])) begin
        n_fail++;
        $display("FAIL fill_move %0d got %0d want %0d",
                 i, cuadro3, cl[i]);
      end
      press3(4);
      exp3[2*(cl[i]-1) +: 2] = (i % 2 == 0) ? 2'b11 : 2'b01;
      n_chk++;
      if ({tab3, val3, lleno3} !== {exp3, 1'b1, (i == 8)}) begin
        n_fail++;
        $display("FAIL fill_mark %0d got %h/%b/%b want %h/1/%b",
                 i, tab3, val3, lleno3, exp3, (i == 8));
      end
    end
    press3(4);
    n_chk++;
    if ({inv3, val3, tab3} !== {2'b10, exp3}) begin
      n_fail++;
      $display("FAIL full_elige got %b%b/%h want 10/%h",
               inv3, val3, tab3, exp3);
    end
    tick();
    nj3 = 1'b1;
    b3[2] = 1'b1;
    tick();
    nj3 = 1'b0;
    n_chk++;
    if ({tab3, lleno3, t1_3, p1_3, p2_3} !== {18'h0, 4'b0100}) begin
      n_fail++;
      $display("FAIL nuevo_clear got %h/%b%b%b%b want 0/0100",
               tab3, lleno3, t1_3, p1_3, p2_3);
    end
    n_chk++;
    if (cuadro3 !== 4'd9) begin
      n_fail++;
      $display("FAIL nuevo_cuadro got %0d want 9", cuadro3);
    end
    tick();
    n_chk++;
    if (cuadro3 !== 4'd9) begin
      n_fail++;
      $display("FAIL nuevo_held_refire got %0d want 9", cuadro3);
    end
    b3[2] = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    int ex [3] = '{10, 14, 14};
    logic [31:0] exp4;
    int c;
    int k = 0;
    n_chk++;
    if (cuadro4 !== 5'd6) begin
      n_fail++;
      $display("FAIL n4_reset got %0d want 6", cuadro4);
    end
    for (int i = 0; i < 3; i++) begin
      press4(1);
      n_chk++;
      if (cuadro4 !== 5'(ex[i])) begin
        n_fail++;
        $display("FAIL n4_arriba %0d got %0d want %0d",
                 i, cuadro4, ex[i]);
      end
    end
    press4(4);
    n_chk++;
    if (tab4 !== 32'h0C00_0000) begin
      n_fail++;
      $display("FAIL n4_elige got %h want 0c000000", tab4);
    end
    tick();
    nj4 = 1'b1;
    tick();
    nj4 = 1'b0;
    for (int i = 0; i < 3; i++) press4(0);
    for (int i = 0; i < 3; i++) press4(2);
    n_chk++;
    if ({tab4, cuadro4} !== {32'h0, 5'd1}) begin
      n_fail++;
      $display("FAIL n4_home got %h/%0d want 0/1", tab4, cuadro4);
    end
    exp4 = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        c = (r % 2 == 0) ? j : 3 - j;
        press4(4);
        exp4[2*(r*4+c) +: 2] = (k % 2 == 0) ? 2'b11 : 2'b01;
        k++;
        if (k >= 15) begin
          n_chk++;
          if ({val4, lleno4} !== {1'b1, (k == 16)}) begin
            n_fail++;
            $display("FAIL n4_lleno k=%0d got %b%b want 1%b",
                     k, val4, lleno4, (k == 16));
          end
        end
        if (j < 3) press4((r % 2 == 0) ? 3 : 2);
      end
      if (r < 3) press4(1);
    end
    n_chk++;
    if ({tab4, cuadro4} !== {exp4, 5'd13}) begin
      n_fail++;
      $display("FAIL n4_board got %h/%0d want %h/13",
               tab4, cuadro4, exp4);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_clamp();
    test_elige();
    test_simul();
    test_habilita();
    test_fill();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_tablero.md
Name: selector_tablero

Overview:
- Parametrised, clocked successor to the game's cell selector.
- Moves a cursor over an N x N board from five push buttons and commits the current player's mark on "elige".
- Owns the turn alternation, rejects occupied cells, and reports when the board is full.
- Sits between the debounced button inputs and the board-display/win-detection logic, which read the flat board vector.

Parameters:
- N, 3, board dimension (N x N cells), legal range 2..15.
- CW, $clog2(N*N+1), cursor width (derived; do not override).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- boton_arriba  input  1  level button, already synchronised/debounced upstream.
- boton_abajo  input  1  level button, same conditioning.
- boton_izq  input  1  level button, same conditioning.
- boton_der  input  1  level button, same conditioning.
- boton_elige  input  1  level button, same conditioning.
- habilita  input  1  1 = placing marks allowed; 0 = elige ignored, movement still allowed.
- nuevo_juego  input  1  synchronous clear of board and turn; cursor is kept.
- cuadro  output  CW  1-based cursor index; bottom-left = 1, row-major, up = +N.
- tablero  output  2*N*N  cell i (1-based) at bits [2i-1:2i-2]; 00 empty, 11 player 1, 01 player 2.
- turno_p1  output  1  1 when player 1 is to move.
- turno_p2  output  1  always the inverse of turno_p1.
- p1_mm  output  1  level: last accepted mark was by player 1.
- p2_mm  output  1  level: last accepted mark was by player 2.
- jugada_valida  output  1  one-cycle pulse when a mark is accepted.
- jugada_invalida  output  1  one-cycle pulse on elige to an occupied cell while habilita=1.
- lleno  output  1  1 when all N*N cells are occupied.

Behaviour:
- **Reset values:**
  - Reset is synchronous, active-high.
  - cuadro = centre: row = col = (N-1)/2, cuadro = row*N+col+1 (N=3 gives 5).
  - tablero = 0; turno_p1 = 1; p1_mm = p2_mm = 0; both pulses = 0; lleno = 0; internal occupied count = 0.
- **Edge detection:**
  - Each button has a registered previous value; press = btn & ~prev.
  - A held button produces exactly one action.
  - prev registers reset to 0, so a button held through reset acts once on the first cycle after reset.
- **Latency:** an action takes effect on the same rising edge where the press is first seen high; outputs are registered and visible the following cycle.
- **Priority (simultaneous presses):** reset > nuevo_juego > abajo > arriba > izq > der > elige. Only the highest-priority press acts; lower ones in that cycle are discarded.
- **Cursor:**
  - Internal row/col registers; cuadro is registered and equal to row*N+col+1.
  - arriba: row++ if row < N-1, else no change.
  - abajo: row-- if row > 0, else no change.
  - der: col++ if col < N-1, else no change.
  - izq: col-- if col > 0, else no change.
  - No wrap-around; cuadro is never 0 or greater than N*N.
- **Elige with habilita=1 and cell empty:**
  - Write 11 if turno_p1, else 01.
  - Set p1_mm/p2_mm to match the mover.
  - Toggle turn; pulse jugada_valida; increment occupied count.
- **Elige with habilita=1 and cell occupied:** board and turn unchanged; pulse jugada_invalida.
- **Elige with habilita=0:** no effect at all (no pulse).
- **lleno:** = (occupied count == N*N), registered. Once full, every elige is invalid by the occupied rule.
- **nuevo_juego:** same as reset for tablero, turno, p1_mm, p2_mm, pulses, count and lleno; cuadro and prev registers are untouched. It has no edge detection and acts every cycle it is high.
- **Reset or nuevo_juego mid-press:** a press in the same cycle is lost; a still-held button does not re-fire afterwards.

Test Plan:
- **Reset and edge behaviour:** reset, N=3 -> cuadro=5, tablero=0, turno_p1=1, lleno=0. Hold boton_arriba 10 cycles -> cuadro=8 once, not repeated.
- **Boundary clamping:** from 5 press izq twice then abajo twice -> cuadro 4, 4, 1, 1. Press der 3x -> 2, 3, 3.
- **Valid then invalid elige:**
  - elige at cuadro=5 -> tablero[9:8]=11, jugada_valida pulse 1 cycle, turno_p1=0, p1_mm=1.
  - elige again at 5 -> jugada_invalida pulse, tablero unchanged, turno_p1 still 0.
- **Simultaneous presses and habilita:**
  - abajo+der+elige rising in the same cycle at cuadro=5 -> cuadro=2, no mark.
  - habilita=0, elige -> no pulse, board unchanged.
- **Fill and restart:**
  - Fill all 9 cells alternately -> cells alternate 11/01, lleno=1 after 9th accepted.
  - nuevo_juego -> tablero=0, lleno=0, turno_p1=1, cuadro retained.
- **Parameter sweep:**
  - N=4: reset cuadro=6 (row=col=1).
  - arriba 3x -> 10, 14, 14.
  - elige at 14 -> tablero[27:26]=11.
  - 16 accepted marks -> lleno=1.
